// File: rtl/filt_load_scheduler.sv
// Layer-level filter load scheduler: sizes the scratchpad into filter slots, issues loads
// while slots are free, and tracks resident filters as a circular buffer for the PE array.
module filt_load_scheduler #(
  parameter int unsigned ADDR_LEN      = 8,
  parameter int unsigned SCRATCH_DEPTH = 16,
  parameter int unsigned CNT_LEN       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [ADDR_LEN-1:0] filt_len,
  input  logic [CNT_LEN-1:0]  num_filt,
  input  logic                load_ready,
  input  logic                consume_done,
  output logic                load_start,
  output logic [ADDR_LEN-1:0] load_base,
  output logic [ADDR_LEN-1:0] filt_base,
  output logic                filt_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    StIdle, StCalc, StCheck, StLaunch, StWait, StDrain, StDone
  } state_e;

  state_e              state_q;
  logic [ADDR_LEN-1:0] len_q;
  logic [CNT_LEN-1:0]  num_q;
  logic [ADDR_LEN:0]   rem_q, lim_q;
  logic [CNT_LEN-1:0]  cap_q, res_cnt_q, issued_q, consumed_q;
  logic [ADDR_LEN-1:0] wr_base_q, rd_base_q;
  logic                seen_low_q;
  logic                err_q, load_start_q, done_q, busy_q;

  logic [ADDR_LEN:0]   len_ext, wr_sum, rd_sum;
  logic [ADDR_LEN-1:0] wr_next, rd_next;
  logic                load_cmp, consume_ok;

  // Slot pointers wrap at the last whole filter slot, not at the scratchpad end.
  always_comb begin
    len_ext    = {1'b0, len_q};
    wr_sum     = {1'b0, wr_base_q} + len_ext;
    rd_sum     = {1'b0, rd_base_q} + len_ext;
    wr_next    = (wr_sum == lim_q) ? '0 : wr_sum[ADDR_LEN-1:0];
    rd_next    = (rd_sum == lim_q) ? '0 : rd_sum[ADDR_LEN-1:0];
    load_cmp   = (state_q == StWait) && load_ready && seen_low_q;
    consume_ok = consume_done && (res_cnt_q != '0) &&
                 (state_q != StIdle) && (state_q != StCalc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      num_q        <= '0;
      rem_q        <= '0;
      lim_q        <= '0;
      cap_q        <= '0;
      res_cnt_q    <= '0;
      issued_q     <= '0;
      consumed_q   <= '0;
      wr_base_q    <= '0;
      rd_base_q    <= '0;
      seen_low_q   <= 1'b0;
      err_q        <= 1'b0;
      load_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      load_start_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            len_q      <= filt_len;
            num_q      <= num_filt;
            rem_q      <= '0;
            lim_q      <= '0;
            cap_q      <= '0;
            res_cnt_q  <= '0;
            issued_q   <= '0;
            consumed_q <= '0;
            wr_base_q  <= '0;
            rd_base_q  <= '0;
            seen_low_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            if (filt_len == '0) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (num_filt == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rem_q   <= (ADDR_LEN+1)'(SCRATCH_DEPTH);
              state_q <= StCalc;
            end
          end
        end
        // One filter slot carved out per cycle until the remainder is too small.
        StCalc: begin
          if (rem_q >= len_ext) begin
            rem_q <= rem_q - len_ext;
            lim_q <= lim_q + len_ext;
            cap_q <= cap_q + CNT_LEN'(1);
          end else if (cap_q == '0) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (issued_q == num_q) begin
            state_q <= StDrain;
          end else if ((res_cnt_q < cap_q) && load_ready) begin
            load_start_q <= 1'b1;
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          issued_q   <= issued_q + CNT_LEN'(1);
          seen_low_q <= 1'b0;
          state_q    <= StWait;
        end
        // Ready only means "finished" once the loader has visibly gone busy.
        StWait: begin
          if (!load_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            wr_base_q <= wr_next;
            state_q   <= StCheck;
          end
        end
        StDrain: begin
          if (consumed_q == num_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (load_cmp && !consume_ok) begin
        res_cnt_q <= res_cnt_q + CNT_LEN'(1);
      end else if (!load_cmp && consume_ok) begin
        res_cnt_q <= res_cnt_q - CNT_LEN'(1);
      end
      if (consume_ok) begin
        consumed_q <= consumed_q + CNT_LEN'(1);
        rd_base_q  <= rd_next;
      end
    end
  end

  assign load_start = load_start_q;
  assign load_base  = wr_base_q;
  assign filt_base  = rd_base_q;
  assign filt_valid = (res_cnt_q != '0);
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_filt_load_scheduler.sv
// Bench for filt_load_scheduler: load bases are scoreboarded, a loader model drops ready per load.
module tb_filt_load_scheduler;
  localparam int AL = 8;
  localparam int CL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, go, consume_done;
  logic [AL-1:0] filt_len;
  logic [CL-1:0] num_filt;
  logic          load_ready, auto_ld, auto_ready, man_ready;
  logic          load_start, filt_valid, busy, done, err;
  logic [AL-1:0] load_base, filt_base;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int load_cnt = 0;
  int drop_len = 6;
  logic [AL-1:0] exp_base_q[$];

  assign load_ready = auto_ld ? auto_ready : man_ready;

  filt_load_scheduler #(.ADDR_LEN(8), .SCRATCH_DEPTH(16), .CNT_LEN(8)) dut (
    .clk(clk), .rst(rst), .go(go), .filt_len(filt_len), .num_filt(num_filt),
    .load_ready(load_ready), .consume_done(consume_done), .load_start(load_start),
    .load_base(load_base), .filt_base(filt_base), .filt_valid(filt_valid),
    .busy(busy), .done(done), .err(err)
  );

  // Scoreboard monitor: every load_start must match the next expected base.
  initial begin
    logic [AL-1:0] exp;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (load_start) begin
        load_cnt++;
        n_checks++;
        if (exp_base_q.size() == 0) begin
          n_errors++;
          $display("FAIL load_base_unexpected: got load at base %0d, required no load", load_base);
        end else begin
          exp = exp_base_q.pop_front();
          if (load_base !== exp) begin
            n_errors++;
            $display("FAIL load_base: got %0d, required %0d", load_base, exp);
          end
        end
      end
    end
  end

  // Loader model: drops ready for drop_len cycles after each load_start.
  initial begin
    int cnt;
    cnt = 0;
    auto_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        auto_ready = 1'b1;
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) auto_ready = 1'b1;
      end else if (load_start && auto_ld) begin
        auto_ready = 1'b0;
        cnt = drop_len;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [AL-1:0] len, input logic [CL-1:0] num);
    filt_len = len;
    num_filt = num;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic consume();
    consume_done = 1'b1;
    tick();
    consume_done = 1'b0;
  endtask

  task automatic wait_load(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (load_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got no load_start in 200 cycles, required one", name);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got no done in 200 cycles, required one", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; consume_done = 1'b0; filt_len = '0; num_filt = '0;
    auto_ld = 1'b1; man_ready = 1'b1;
    tick(3);
    n_checks++;
    if ({load_start, load_base, filt_base, filt_valid, busy, done, err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b/%0d/%0d/%b/%b/%b/%b, required all 0",
               load_start, load_base, filt_base, filt_valid, busy, done, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    int d0;
    d0 = done_cnt;
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    start(8'd5, 8'd2);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b, required 1", busy); end
    cyc = 1;
    while (!load_start && cyc < 50) begin tick(); cyc++; end
    n_checks++;
    if (cyc != 6) begin
      n_errors++;
      $display("FAIL basic_first_load_cycle: got %0d, required 6", cyc);
    end
    tick(40);
    n_checks++;
    if (filt_valid !== 1'b1 || filt_base !== 8'd0) begin
      n_errors++;
      $display("FAIL basic_resident: got valid %b base %0d, required 1 0", filt_valid, filt_base);
    end
    consume();
    n_checks++;
    if (filt_base !== 8'd5) begin
      n_errors++; $display("FAIL basic_consume1: got %0d, required 5", filt_base);
    end
    consume();
    n_checks++;
    if (filt_base !== 8'd10 || filt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_consume2: got base %0d valid %b, required 10 0", filt_base, filt_valid);
    end
    wait_done("basic_done");
    tick(2);
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || err !== 1'b0 || exp_base_q.size() != 0) begin
      n_errors++;
      $display("FAIL basic_end: got dones %0d busy %b err %b pending %0d, required 1 0 0 0",
               done_cnt - d0, busy, err, exp_base_q.size());
    end
  endtask

  task automatic test_capacity();
    int l0;
    int d0;
    logic [AL-1:0] exp_rd[4];
    exp_rd = '{8'd10, 8'd0, 8'd5, 8'd10};
    l0 = load_cnt;
    d0 = done_cnt;
    foreach (exp_rd[i]) exp_base_q.push_back(i == 3 ? 8'd5 : exp_rd[(i + 2) % 4] - 8'd10 + 8'd10);
    // Loads go to 0,5,10,0,5: rebuild explicitly to keep the expectation readable.
    exp_base_q.delete();
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    exp_base_q.push_back(8'd10);
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    start(8'd5, 8'd5);
    tick(80);
    n_checks++;
    if (load_cnt - l0 != 3 || filt_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL cap_full: got loads %0d valid %b, required 3 1", load_cnt - l0, filt_valid);
    end
    consume();
    n_checks++;
    if (filt_base !== 8'd5) begin
      n_errors++; $display("FAIL cap_consume1: got %0d, required 5", filt_base);
    end
    tick(20);
    n_checks++;
    if (load_cnt - l0 != 4) begin
      n_errors++; $display("FAIL cap_fourth_load: got %0d loads, required 4", load_cnt - l0);
    end
    for (int k = 0; k < 4; k++) begin
      consume();
      n_checks++;
      if (filt_base !== exp_rd[k]) begin
        n_errors++;
        $display("FAIL cap_consume%0d: got %0d, required %0d", k + 2, filt_base, exp_rd[k]);
      end
      tick(20);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || filt_valid !== 1'b0 || load_cnt - l0 != 5) begin
      n_errors++;
      $display("FAIL cap_end: got dones %0d busy %b valid %b loads %0d, required 1 0 0 5",
               done_cnt - d0, busy, filt_valid, load_cnt - l0);
    end
  endtask

  task automatic test_simultaneous();
    auto_ld = 1'b0;
    man_ready = 1'b1;
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    exp_base_q.push_back(8'd10);
    start(8'd5, 8'd3);
    wait_load("sim_load1");
    man_ready = 1'b0;
    tick(3);
    man_ready = 1'b1;
    tick();
    n_checks++;
    if (filt_valid !== 1'b1 || filt_base !== 8'd0) begin
      n_errors++;
      $display("FAIL sim_first: got valid %b base %0d, required 1 0", filt_valid, filt_base);
    end
    wait_load("sim_load2");
    man_ready = 1'b0;
    tick(3);
    man_ready = 1'b1;
    consume_done = 1'b1;
    tick();
    consume_done = 1'b0;
    n_checks++;
    if (filt_valid !== 1'b1 || filt_base !== 8'd5) begin
      n_errors++;
      $display("FAIL sim_both: got valid %b base %0d, required 1 5", filt_valid, filt_base);
    end
    wait_load("sim_load3");
    man_ready = 1'b0;
    tick(3);
    man_ready = 1'b1;
    tick();
    consume();
    n_checks++;
    if (filt_valid !== 1'b1 || filt_base !== 8'd10) begin
      n_errors++;
      $display("FAIL sim_consume2: got valid %b base %0d, required 1 10", filt_valid, filt_base);
    end
    consume();
    n_checks++;
    if (filt_valid !== 1'b0 || filt_base !== 8'd0) begin
      n_errors++;
      $display("FAIL sim_consume3: got valid %b base %0d, required 0 0", filt_valid, filt_base);
    end
    wait_done("sim_done");
    tick(2);
    auto_ld = 1'b1;
  endtask

  task automatic test_errors();
    int l0;
    l0 = load_cnt;
    start(8'd0, 8'd3);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_errors++; $display("FAIL err_len0: got done %b err %b, required 1 1", done, err);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got done %b busy %b err %b, required 0 0 1", done, busy, err);
    end
    start(8'd17, 8'd3);
    n_checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL err_clear_on_go: got err %b done %b, required 0 0", err, done);
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || done !== 1'b1) begin
      n_errors++; $display("FAIL err_len17: got err %b done %b, required 1 1", err, done);
    end
    tick(2);
    start(8'd5, 8'd0);
    n_checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_errors++; $display("FAIL err_num0: got done %b err %b, required 1 0", done, err);
    end
    tick(3);
    n_checks++;
    if (load_cnt != l0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL err_no_loads: got loads %0d busy %b, required 0 0", load_cnt - l0, busy);
    end
  endtask

  task automatic test_ignore();
    int l0;
    int d0;
    l0 = load_cnt;
    d0 = done_cnt;
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    start(8'd5, 8'd2);
    wait_load("ign_load1");
    tick(2);
    consume();
    filt_len = 8'd1;
    num_filt = 8'd9;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(40);
    n_checks++;
    if (load_cnt - l0 != 2 || filt_valid !== 1'b1 || filt_base !== 8'd0) begin
      n_errors++;
      $display("FAIL ign_state: got loads %0d valid %b base %0d, required 2 1 0",
               load_cnt - l0, filt_valid, filt_base);
    end
    consume();
    tick(3);
    n_checks++;
    if (filt_base !== 8'd5 || filt_valid !== 1'b1 || done_cnt != d0) begin
      n_errors++;
      $display("FAIL ign_consume1: got base %0d valid %b dones %0d, required 5 1 0",
               filt_base, filt_valid, done_cnt - d0);
    end
    consume();
    wait_done("ign_done");
    tick(2);
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ign_end: got dones %0d busy %b, required 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_wait();
    int d0;
    d0 = done_cnt;
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    start(8'd5, 8'd2);
    wait_load("rst_load1");
    tick(2);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, load_start, filt_valid, load_base, filt_base, done, err} !== '0) begin
      n_errors++;
      $display("FAIL rst_wait: got busy %b ls %b valid %b lb %0d fb %0d done %b err %b, required 0",
               busy, load_start, filt_valid, load_base, filt_base, done, err);
    end
    tick();
    rst = 1'b0;
    exp_base_q.delete();
    tick(15);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_no_done: got dones %0d busy %b, required 0 0", done_cnt - d0, busy);
    end
    exp_base_q.push_back(8'd0);
    exp_base_q.push_back(8'd5);
    start(8'd5, 8'd2);
    tick(45);
    consume();
    consume();
    n_checks++;
    if (filt_base !== 8'd10) begin
      n_errors++; $display("FAIL rst_rerun_base: got %0d, required 10", filt_base);
    end
    wait_done("rst_rerun_done");
    tick(2);
    n_checks++;
    if (done_cnt - d0 != 1 || exp_base_q.size() != 0) begin
      n_errors++;
      $display("FAIL rst_rerun_end: got dones %0d pending %0d, required 1 0",
               done_cnt - d0, exp_base_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_capacity();
    test_simultaneous();
    test_errors();
    test_ignore();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/filt_load_scheduler.md
# filt_load_scheduler

Sequences the filter loader across a whole layer: computes how many filters fit in the filter scratchpad, issues one `load_start` per filter to the filter read module while there is free room, and tracks resident filters as a circular slot buffer. The PE array consumes the oldest filter via `filt_base`/`filt_valid`/`consume_done`. The block sits between the layer controller (`go`/`done`) and the filter read datapath (`load_start`/`load_ready`).

## Interface
- Parameters:
  - ADDR_LEN, default 8: scratchpad address width.
  - SCRATCH_DEPTH, default 16: scratchpad words; must satisfy SCRATCH_DEPTH ≤ 2^ADDR_LEN.
  - CNT_LEN, default 8: width of filter counts.
- Ports:
  - clk  in  1  clock; all state changes on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - go  in  1  start layer; sampled only in IDLE.
  - filt_len  in  ADDR_LEN  words per filter; captured on go.
  - num_filt  in  CNT_LEN  filters in layer; captured on go.
  - load_ready  in  1  filter read module idle (its ready output).
  - consume_done  in  1  1-cycle pulse: PE finished with oldest filter.
  - load_start  out  1  1-cycle start pulse to the filter read module.
  - load_base  out  ADDR_LEN  scratch base for the load in flight (wr_base).
  - filt_base  out  ADDR_LEN  base of oldest resident filter (rd_base).
  - filt_valid  out  1  res_cnt != 0.
  - busy  out  1  state != IDLE.
  - done  out  1  1-cycle pulse at layer end.
  - err  out  1  bad configuration; sticky until next accepted go.

## Operation
- Reset: state IDLE; all registers and outputs 0 (`err` = 0).
- Registers:
  - rem, lim (ADDR_LEN+1 bits): remaining depth and store limit.
  - cap, res_cnt (CNT_LEN): slot capacity and resident count.
  - issued, consumed (CNT_LEN): loads issued, filters consumed.
  - wr_base, rd_base (ADDR_LEN): write and read slot bases.
  - seen_low: loader has dropped ready since launch.
- IDLE: on go, capture inputs and clear counters/pointers; err ← 0.
  - filt_len == 0 → err ← 1, go to DONE.
  - else num_filt == 0 → DONE.
  - else rem ← SCRATCH_DEPTH, go to CALC.
- CALC (sequential divide), each cycle:
  - rem ≥ filt_len → rem −= filt_len, cap++, lim += filt_len.
  - else cap == 0 → err ← 1, go to DONE; otherwise go to CHECK.
- CHECK:
  - issued == num_filt → DRAIN.
  - else res_cnt < cap and load_ready → LAUNCH.
  - else stay.
- LAUNCH: load_start = 1 for exactly this cycle; issued++; seen_low ← 0; go to WAIT.
- WAIT:
  - load_ready == 0 → seen_low ← 1.
  - load_ready == 1 and seen_low → load complete: res_cnt++; wr_base ← (wr_base + filt_len == lim) ? 0 : wr_base + filt_len; go to CHECK.
- DRAIN: consumed == num_filt → DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Consume (any state except IDLE/CALC): consume_done && res_cnt != 0 → res_cnt−−, consumed++, rd_base advances with the same wrap rule. consume_done with res_cnt == 0 is ignored.
- Simultaneous load-complete and consume in one cycle: res_cnt is net unchanged; both pointers advance.
- go outside IDLE is ignored. rst at any point aborts, returns to IDLE with all outputs 0, and no done pulse.

## Timing
- go → busy = 1 the next cycle.
- CALC lasts cap+1 cycles.
- First load_start: the cycle after CHECK is entered, provided load_ready = 1.
- Load completion is registered on the edge where WAIT sees load_ready = 1 after seen_low. res_cnt/filt_valid update the following cycle. The next load_start comes no earlier than 2 cycles later (CHECK, LAUNCH).
- consume_done → filt_base/res_cnt update the next cycle.
- Layer end: done pulses 1 cycle after DRAIN sees consumed == num_filt; busy = 0 the cycle after done.

## Test plan
- DEPTH=16, filt_len=5, num_filt=2, loader model dropping ready for 6 cycles per load → cap=3, lim=15, CALC 4 cycles; load_base 0 then 5; consume twice → filt_base 0→5→10; done once.
- filt_len=5, num_filt=5, consumer idle until 3 resident → no 4th load_start while res_cnt=3. One consume → 4th load at base 0 (wrap). All consumed → done.
- Load completion and consume_done in the same cycle → res_cnt unchanged; wr_base and rd_base both advance.
- filt_len=0 → err=1 and done pulse, no load_start. filt_len=17 (DEPTH=16) → err after 1 CALC cycle. num_filt=0 → done, err=0.
- consume_done with res_cnt=0 → ignored, consumed unchanged. go pulsed while busy → ignored.
- rst asserted in WAIT → next cycle IDLE, busy=0, load_start=0, no done. A fresh go then runs normally from base 0.
